tdm_noc_slot_table_conf_rx: RTL and testbench
=============================================

// Module: tdm_noc_slot_table_conf_rx
// PURPOSE
// - Router-local endpoint of the dedicated slot-table configuration network, one instance per router.
// - Accepts control flits from a daisy-chained link and decodes packets addressed to ROUTER_ID into single-entry writes
//   on the lut_conf_* bus shared by all tdm_noc_slot_table instances of that router.
// - Forwards packets for other routers unchanged to the next hop.
// PARAMETERS
// - PORTS      5     router output/input port count; lut_conf widths derive from it
// - LUT_SIZE   16    slots per slot table (power of two)
// - ROUTER_ID  'x    this router's ID
// - ID_W       4     width of destination ID field
// - CTRL_W     16    control flit width
// PORTS
// - clk             in   1                    clock
// - rst             in   1                    sync reset, active-high
// - in_flit         in   CTRL_W               flit from previous hop
// - in_valid        in   1                    in_flit valid
// - in_ready        out  1                    flit accepted when in_valid&&in_ready
// - out_flit        out  CTRL_W               flit to next hop
// - out_valid       out  1                    out_flit valid
// - out_ready       in   1                    next hop accepts
// - lut_conf_data   out  $clog2(PORTS+1)      input select to write
// - lut_conf_sel    out  $clog2(PORTS)        target output port / table
// - lut_conf_slot   out  $clog2(LUT_SIZE)     slot index
// - lut_conf_valid  out  1                    one-cycle write strobe
// - conf_done       out  1                    one-cycle pulse: last local entry written
// - proto_err       out  1                    one-cycle pulse: protocol violation
// BEHAVIOUR
// - Flit format: bit CTRL_W-1 = HDR flag.
//   - Header:  [CTRL_W-2 -: ID_W] = dest, [7:0] = N (payload count, 0 legal).
//   - Payload (flag 0): [S-1:0] slot, [S+P-1:S] sel, [S+P+D-1:S+P] data, where S/P/D are the lut_conf_slot/sel/data widths.
// - FSM states IDLE, LOCAL, FWD; 8-bit counter rem.
//   - IDLE: on accepted header:
//     - N==0: stay IDLE. If dest==ROUTER_ID, pulse conf_done next cycle; otherwise forward the header.
//     - dest==ROUTER_ID: go LOCAL, rem=N, header consumed.
//     - Otherwise: go FWD, rem=N, header forwarded.
//     - Accepted payload flit in IDLE: dropped, proto_err pulses next cycle.
//   - LOCAL: each accepted payload flit -> lut_conf_* registered, lut_conf_valid=1 exactly the following cycle; rem--.
//     - On rem 1->0: return IDLE; conf_done pulses together with that last lut_conf_valid.
//   - FWD: each accepted flit is forwarded; rem--; at 0 return IDLE.
//   - Header flit received in LOCAL/FWD: proto_err pulse; flit treated as new header (IDLE decode applied same cycle).
//     Remaining count is abandoned.
// - Handshake:
//   - in_ready = 1 in LOCAL; in_ready = !out_valid || out_ready in IDLE and FWD.
//   - Output register: out_valid/out_flit hold stable while out_valid && !out_ready.
//   - Back-to-back flits sustain 1 flit/cycle when out_ready=1.
// - Local consumption never stalls.
//   - No validation of sel/slot/data range; slot tables ignore non-matching sel.
// - Latency: accepted flit -> lut_conf_valid or out_valid at cycle +1.
// - Reset (any state, mid-packet included): state IDLE, rem=0.
//   - Outputs: out_valid=0, out_flit=0, lut_conf_valid=0, lut_conf_*=0, conf_done=0, proto_err=0.
//   - Partial packets are lost; upstream resends.
// TESTING
// - Local, ID=3: header(dest 3, N=2), payloads (slot 5, sel 1, data 2), (slot 15, sel 4, data 0), back-to-back.
//   -> lut_conf_valid on two consecutive cycles with those values; conf_done with 2nd; out_valid stays 0.
// - Forward, ID=3: header(dest 7, N=3) + 3 payloads.
//   -> 4 identical flits on out_flit in order; no lut_conf_valid.
// - Backpressure: forwarded packet with out_ready=0 for 5 cycles.
//   -> in_ready=0, out_flit stable, no flit lost or duplicated after release.
// - Protocol errors:
//   - Payload in IDLE -> proto_err, dropped.
//   - Header(dest 3, N=4) after 1 payload, then a new header(dest 3, N=1) -> proto_err; one further write only.
// - Zero-length: header(dest 3, N=0) -> conf_done pulse, no write.
//   - Header(dest 9, N=0) -> header forwarded only.
// - Reset mid-LOCAL after 1 of 3 payloads -> all outputs 0; next packet decodes correctly from IDLE.

Source files
------------

// File: rtl/tdm_noc_slot_table_conf_rx.sv
// Router-local receiver of the slot-table configuration network.
// Packets addressed to this router become single-entry writes on the
// lut_conf_* bus; packets for other routers pass through a one-flit
// output register towards the next hop.
module tdm_noc_slot_table_conf_rx #(
    parameter int PORTS     = 5,
    parameter int LUT_SIZE  = 16,
    parameter int ROUTER_ID = 0,
    parameter int ID_W      = 4,
    parameter int CTRL_W    = 16,
    localparam int DATA_W   = $clog2(PORTS + 1),
    localparam int SEL_W    = $clog2(PORTS),
    localparam int SLOT_W   = $clog2(LUT_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] in_flit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CTRL_W-1:0] out_flit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] lut_conf_data,
    output logic [SEL_W-1:0]  lut_conf_sel,
    output logic [SLOT_W-1:0] lut_conf_slot,
    output logic              lut_conf_valid,
    output logic              conf_done,
    output logic              proto_err
);

    localparam logic [ID_W-1:0] MY_ID = ID_W'(ROUTER_ID);

    typedef enum logic [1:0] {IDLE, LOCAL, FWD} state_t;

    state_t          state;
    logic [7:0]      rem;

    logic            is_hdr;
    logic [ID_W-1:0] dest;
    logic [7:0]      hdr_n;
    logic            hdr_local;
    logic            out_free;
    logic            accept;

    assign is_hdr    = in_flit[CTRL_W-1];
    assign dest      = in_flit[CTRL_W-2 -: ID_W];
    assign hdr_n     = in_flit[7:0];
    assign hdr_local = (dest == MY_ID);
    assign out_free  = !out_valid || out_ready;
    assign in_ready  = (state == LOCAL) ? 1'b1 : out_free;
    assign accept    = in_valid && in_ready;

    // Packet decode, local write generation and forwarding output register.
    // A stray header arriving in LOCAL is decoded like any header; if it is
    // for another router while the output register is still stalled it
    // cannot be forwarded and is lost along with the broken packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rem            <= 8'd0;
            out_valid      <= 1'b0;
            out_flit       <= '0;
            lut_conf_valid <= 1'b0;
            lut_conf_data  <= '0;
            lut_conf_sel   <= '0;
            lut_conf_slot  <= '0;
            conf_done      <= 1'b0;
            proto_err      <= 1'b0;
        end else begin
            lut_conf_valid <= 1'b0;
            conf_done      <= 1'b0;
            proto_err      <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (is_hdr) begin
                    if (state != IDLE) begin
                        proto_err <= 1'b1;
                    end
                    rem <= hdr_n;
                    if (hdr_local) begin
                        if (hdr_n == 8'd0) begin
                            conf_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= LOCAL;
                        end
                    end else begin
                        if (out_free) begin
                            out_valid <= 1'b1;
                            out_flit  <= in_flit;
                        end
                        state <= (hdr_n == 8'd0) ? IDLE : FWD;
                    end
                end else begin
                    case (state)
                        LOCAL: begin
                            lut_conf_valid <= 1'b1;
                            lut_conf_slot  <= in_flit[SLOT_W-1:0];
                            lut_conf_sel   <= in_flit[SLOT_W +: SEL_W];
                            lut_conf_data  <= in_flit[SLOT_W+SEL_W +: DATA_W];
                            rem            <= rem - 8'd1;
                            if (rem == 8'd1) begin
                                conf_done <= 1'b1;
                                state     <= IDLE;
                            end
                        end
                        FWD: begin
                            out_valid <= 1'b1;
                            out_flit  <= in_flit;
                            rem       <= rem - 8'd1;
                            if (rem == 8'd1) begin
                                state <= IDLE;
                            end
                        end
                        default: begin
                            proto_err <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_noc_slot_table_conf_rx.sv
// Testbench for tdm_noc_slot_table_conf_rx with ROUTER_ID = 3:
// a cycle-exact directed vector table followed by random packet traffic
// checked against a packet-level expectation model.
module tb_tdm_noc_slot_table_conf_rx;

    logic        clk;
    logic        rst;
    logic [15:0] in_flit;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_flit;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  lut_conf_data;
    logic [2:0]  lut_conf_sel;
    logic [3:0]  lut_conf_slot;
    logic        lut_conf_valid;
    logic        conf_done;
    logic        proto_err;

    int vecs = 0;
    int miscompares = 0;

    tdm_noc_slot_table_conf_rx #(
        .PORTS(5), .LUT_SIZE(16), .ROUTER_ID(3), .ID_W(4), .CTRL_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
        .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
        .lut_conf_data(lut_conf_data), .lut_conf_sel(lut_conf_sel),
        .lut_conf_slot(lut_conf_slot), .lut_conf_valid(lut_conf_valid),
        .conf_done(conf_done), .proto_err(proto_err)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          v;
        logic [15:0] flit;
        bit          ordy;
        bit          rdy;
        bit          ov;
        logic [15:0] of;
        bit          lv;
        logic [3:0]  slot;
        logic [2:0]  sel;
        logic [2:0]  data;
        bit          cd;
        bit          pe;
        bit          chkz;
    } vec_t;

    typedef struct {
        bit         wr;
        bit         last;
        logic [3:0] slot;
        logic [2:0] sel;
        logic [2:0] data;
    } ev_t;

    vec_t        tbl[$];
    logic [15:0] stim_q[$];
    logic [15:0] fwd_q[$];
    ev_t         ev_q[$];

    function automatic logic [15:0] hdr(input int d, input int n);
        return 16'(32'h8000 | ((d & 15) << 11) | (n & 255));
    endfunction

    function automatic logic [15:0] pay(input int slot, input int sel, input int data);
        return 16'(((data & 7) << 7) | ((sel & 7) << 4) | (slot & 15));
    endfunction

    function automatic vec_t mkv(input bit r, input bit v, input logic [15:0] f, input bit ordy,
                                 input bit rdy, input bit ov, input logic [15:0] of,
                                 input bit lv, input int slot, input int sel, input int data,
                                 input bit cd, input bit pe, input bit chkz);
        vec_t x;
        x.rst = r; x.v = v; x.flit = f; x.ordy = ordy;
        x.rdy = rdy; x.ov = ov; x.of = of; x.lv = lv;
        x.slot = 4'(slot); x.sel = 3'(sel); x.data = 3'(data);
        x.cd = cd; x.pe = pe; x.chkz = chkz;
        return x;
    endfunction

    task automatic applyStimulus(input bit r, input bit v, input logic [15:0] f, input bit ordy);
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_flit   = f;
        out_ready = ordy;
        #1;
    endtask

    task automatic checkOutput(input vec_t e, input bit rdy_s, input int idx);
        bit bad;
        bad = (rdy_s !== e.rdy) || (out_valid !== e.ov) ||
              ((e.ov || e.chkz) && (out_flit !== e.of)) ||
              (lut_conf_valid !== e.lv) ||
              ((e.lv || e.chkz) && ({lut_conf_slot, lut_conf_sel, lut_conf_data} !== {e.slot, e.sel, e.data})) ||
              (conf_done !== e.cd) || (proto_err !== e.pe);
        vecs++;
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL vec%0d: got rdy=%b ov=%b of=%h lv=%b slot=%0d sel=%0d data=%0d cd=%b pe=%b, want rdy=%b ov=%b of=%h lv=%b slot=%0d sel=%0d data=%0d cd=%b pe=%b",
                     idx, rdy_s, out_valid, out_flit, lut_conf_valid, lut_conf_slot, lut_conf_sel,
                     lut_conf_data, conf_done, proto_err, e.rdy, e.ov, e.of, e.lv, e.slot, e.sel,
                     e.data, e.cd, e.pe);
        end
    endtask

    // Directed table, then random traffic, then summary.
    initial begin
        bit          rdy_s;
        bit          acc;
        bit          xfer;
        int          cyc;
        logic [15:0] h;
        logic [15:0] f;
        logic [15:0] exp_f;
        ev_t         ev;
        ev_t         got;

        rst = 1'b1; in_valid = 1'b0; in_flit = 16'h0; out_ready = 1'b1;

        // Reset state.
        tbl.push_back(mkv(1,0,16'h0,1, 1, 0,16'h0, 0,0,0,0, 0,0,1));
        // Local packet: two back-to-back writes, conf_done with the second.
        tbl.push_back(mkv(0,1,hdr(3,2),1,      1, 0,16'h0, 0,0,0,0, 0,0,0));
        tbl.push_back(mkv(0,1,pay(5,1,2),1,    1, 0,16'h0, 1,5,1,2, 0,0,0));
        tbl.push_back(mkv(0,1,pay(15,4,0),1,   1, 0,16'h0, 1,15,4,0, 1,0,0));
        tbl.push_back(mkv(0,0,16'h0,1,         1, 0,16'h0, 0,0,0,0, 0,0,0));
        // Forwarded packet: four flits in order.
        tbl.push_back(mkv(0,1,hdr(7,3),1,      1, 1,hdr(7,3), 0,0,0,0, 0,0,0));
        tbl.push_back(mkv(0,1,pay(1,2,3),1,    1, 1,pay(1,2,3), 0,0,0,0, 0,0,0));
        tbl.push_back(mkv(0,1,pay(2,3,4),1,    1, 1,pay(2,3,4), 0,0,0,0, 0,0,0));
        tbl.push_back(mkv(0,1,pay(3,0,1),1,    1, 1,pay(3,0,1), 0,0,0,0, 0,0,0));
        tbl.push_back(mkv(0,0,16'h0,1,         1, 0,16'h0, 0,0,0,0, 0,0,0));
        // Payload in IDLE: dropped with proto_err.
        tbl.push_back(mkv(0,1,pay(6,1,1),1,    1, 0,16'h0, 0,0,0,0, 0,1,0));
        tbl.push_back(mkv(0,0,16'h0,1,         1, 0,16'h0, 0,0,0,0, 0,0,0));
        // New header mid-packet: abandon count, exactly one further write.
        tbl.push_back(mkv(0,1,hdr(3,4),1,      1, 0,16'h0, 0,0,0,0, 0,0,0));
        tbl.push_back(mkv(0,1,pay(1,1,1),1,    1, 0,16'h0, 1,1,1,1, 0,0,0));
        tbl.push_back(mkv(0,1,hdr(3,1),1,      1, 0,16'h0, 0,0,0,0, 0,1,0));
        tbl.push_back(mkv(0,1,pay(9,2,5),1,    1, 0,16'h0, 1,9,2,5, 1,0,0));
        tbl.push_back(mkv(0,1,pay(4,4,4),1,    1, 0,16'h0, 0,0,0,0, 0,1,0));
        // Zero-length packets.
        tbl.push_back(mkv(0,1,hdr(3,0),1,      1, 0,16'h0, 0,0,0,0, 1,0,0));
        tbl.push_back(mkv(0,1,hdr(9,0),1,      1, 1,hdr(9,0), 0,0,0,0, 0,0,0));
        tbl.push_back(mkv(0,0,16'h0,1,         1, 0,16'h0, 0,0,0,0, 0,0,0));
        // Backpressure: header parked, next flit held off for five cycles.
        tbl.push_back(mkv(0,1,hdr(7,2),0,      1, 1,hdr(7,2), 0,0,0,0, 0,0,0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mkv(0,1,pay(10,5,6),0, 0, 1,hdr(7,2), 0,0,0,0, 0,0,0));
        tbl.push_back(mkv(0,1,pay(10,5,6),1,   1, 1,pay(10,5,6), 0,0,0,0, 0,0,0));
        tbl.push_back(mkv(0,1,pay(11,6,7),1,   1, 1,pay(11,6,7), 0,0,0,0, 0,0,0));
        tbl.push_back(mkv(0,0,16'h0,1,         1, 0,16'h0, 0,0,0,0, 0,0,0));
        // Reset in the middle of a local packet, then a clean packet.
        tbl.push_back(mkv(0,1,hdr(3,3),1,      1, 0,16'h0, 0,0,0,0, 0,0,0));
        tbl.push_back(mkv(0,1,pay(2,2,2),1,    1, 0,16'h0, 1,2,2,2, 0,0,0));
        tbl.push_back(mkv(1,1,pay(3,3,3),1,    1, 0,16'h0, 0,0,0,0, 0,0,1));
        tbl.push_back(mkv(0,1,hdr(3,1),1,      1, 0,16'h0, 0,0,0,0, 0,0,0));
        tbl.push_back(mkv(0,1,pay(7,3,5),1,    1, 0,16'h0, 1,7,3,5, 1,0,0));
        tbl.push_back(mkv(0,0,16'h0,1,         1, 0,16'h0, 0,0,0,0, 0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].rst, tbl[i].v, tbl[i].flit, tbl[i].ordy);
            rdy_s = in_ready;
            @(posedge clk);
            #1;
            checkOutput(tbl[i], rdy_s, i);
        end

        // Random well-formed packets; expectations follow the routing rules:
        // local packets become one write per payload (last flagged done, or
        // a bare done when empty), other packets reappear verbatim in order.
        for (int p = 0; p < 150; p++) begin
            int d;
            int n;
            d = ($urandom_range(0, 1) == 1) ? 3 : int'($urandom_range(0, 15));
            n = $urandom_range(0, 5);
            h = hdr(d, n);
            h[10:8] = 3'($urandom);
            stim_q.push_back(h);
            if (d != 3) fwd_q.push_back(h);
            if (d == 3 && n == 0) begin
                ev.wr = 1'b0; ev.last = 1'b1; ev.slot = 4'd0; ev.sel = 3'd0; ev.data = 3'd0;
                ev_q.push_back(ev);
            end
            for (int k = 0; k < n; k++) begin
                f = 16'($urandom) & 16'h7FFF;
                stim_q.push_back(f);
                if (d == 3) begin
                    ev.wr = 1'b1; ev.last = (k == n - 1);
                    ev.slot = f[3:0]; ev.sel = f[6:4]; ev.data = f[9:7];
                    ev_q.push_back(ev);
                end else begin
                    fwd_q.push_back(f);
                end
            end
        end

        cyc = 0;
        while ((stim_q.size() > 0 || fwd_q.size() > 0 || ev_q.size() > 0) && cyc < 20000) begin
            cyc++;
            @(negedge clk);
            rst       = 1'b0;
            in_valid  = (stim_q.size() > 0) && ($urandom_range(0, 4) != 0);
            in_flit   = (stim_q.size() > 0) ? stim_q[0] : 16'h0;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc  = in_valid && in_ready;
            xfer = out_valid && out_ready;
            if (xfer) begin
                vecs++;
                if (fwd_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL fwd_extra: got out_flit=%h, want no flit", out_flit);
                end else begin
                    exp_f = fwd_q.pop_front();
                    if (out_flit !== exp_f) begin
                        miscompares++;
                        $display("[TB] FAIL fwd_flit: got %h, want %h", out_flit, exp_f);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (acc) void'(stim_q.pop_front());
            if (lut_conf_valid || conf_done) begin
                vecs++;
                got.wr = lut_conf_valid; got.last = conf_done;
                got.slot = lut_conf_slot; got.sel = lut_conf_sel; got.data = lut_conf_data;
                if (ev_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL conf_extra: got lv=%b cd=%b, want none", got.wr, got.last);
                end else begin
                    ev = ev_q.pop_front();
                    if (got.wr !== ev.wr || got.last !== ev.last ||
                        (ev.wr && {got.slot, got.sel, got.data} !== {ev.slot, ev.sel, ev.data})) begin
                        miscompares++;
                        $display("[TB] FAIL conf_event: got lv=%b cd=%b slot=%0d sel=%0d data=%0d, want lv=%b cd=%b slot=%0d sel=%0d data=%0d",
                                 got.wr, got.last, got.slot, got.sel, got.data,
                                 ev.wr, ev.last, ev.slot, ev.sel, ev.data);
                    end
                end
            end
            if (proto_err) begin
                vecs++;
                miscompares++;
                $display("[TB] FAIL proto_err: got 1, want 0 on well-formed traffic");
            end
        end

        vecs++;
        if (stim_q.size() > 0 || fwd_q.size() > 0 || ev_q.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d/%0d/%0d pending stim/fwd/conf, want 0/0/0",
                     stim_q.size(), fwd_q.size(), ev_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
